seg_scan_driver: RTL and testbench

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_pkg.sv | 51 +++++
 rtl/bin2bcd_seq.sv | 78 +++++++
 rtl/seg_scan_driver.sv | 165 ++++++++++++++++
 tb/tb_seg_scan_driver.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Font codes are active-low, bit 0 = segment a.
package seg_pkg;

   typedef logic [3:0] bcd_t;

   typedef enum logic [1:0] {
      BCD_IDLE,
      BCD_BUSY,
      BCD_DONE
   } bcd_state_t;

   typedef struct packed {
      logic dash;
      bcd_t tens;
      bcd_t ones;
   } disp_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   localparam logic [6:0] SEG_0 = 7'h40;
   localparam logic [6:0] SEG_1 = 7'h79;
   localparam logic [6:0] SEG_2 = 7'h24;
   localparam logic [6:0] SEG_3 = 7'h30;
   localparam logic [6:0] SEG_4 = 7'h19;
   localparam logic [6:0] SEG_5 = 7'h12;
   localparam logic [6:0] SEG_6 = 7'h02;
   localparam logic [6:0] SEG_7 = 7'h78;
   localparam logic [6:0] SEG_8 = 7'h00;
   localparam logic [6:0] SEG_9 = 7'h10;

   function automatic logic [6:0] seg_font(input bcd_t d);
      logic [6:0] s;
      case (d)
         4'd0:    s = SEG_0;
         4'd1:    s = SEG_1;
         4'd2:    s = SEG_2;
         4'd3:    s = SEG_3;
         4'd4:    s = SEG_4;
         4'd5:    s = SEG_5;
         4'd6:    s = SEG_6;
         4'd7:    s = SEG_7;
         4'd8:    s = SEG_8;
         4'd9:    s = SEG_9;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to BCD converter (shift-add-3).
// Start to done is 9 cycles; start is ignored unless idle.
module bin2bcd_seq
   import seg_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] bin,
   output logic       busy,
   output logic       done,
   output bcd_t       hund,
   output bcd_t       tens,
   output bcd_t       ones
);

   bcd_state_t  state_q;
   bcd_state_t  state_d;
   logic [19:0] sh_q;
   logic [2:0]  cnt_q;

   // one shift-add-3 iteration over the {hund,tens,ones,bin} register
   function automatic logic [19:0] step(input logic [19:0] s);
      logic [19:0] t;
      t = s;
      if (t[11:8] >= 4'd5)
         t[11:8] = t[11:8] + 4'd3;
      if (t[15:12] >= 4'd5)
         t[15:12] = t[15:12] + 4'd3;
      if (t[19:16] >= 4'd5)
         t[19:16] = t[19:16] + 4'd3;
      return {t[18:0], 1'b0};
   endfunction

   // state register, cleared by reset so a conversion aborts silently
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_q <= BCD_IDLE;
      else
         state_q <= state_d;
   end

   // next state: eight busy cycles, then one done cycle
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         BCD_IDLE: if (start) state_d = BCD_BUSY;
         BCD_BUSY: if (cnt_q == 3'd7) state_d = BCD_DONE;
         BCD_DONE: state_d = BCD_IDLE;
         default:  state_d = BCD_IDLE;
      endcase
   end

   // handshake outputs decoded from state
   always_comb begin
      busy = (state_q == BCD_BUSY);
      done = (state_q == BCD_DONE);
   end

   // shift register and iteration counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_q  <= '0;
         cnt_q <= '0;
      end else if (state_q == BCD_IDLE && start) begin
         sh_q  <= {12'd0, bin};
         cnt_q <= '0;
      end else if (state_q == BCD_BUSY) begin
         sh_q  <= step(sh_q);
         cnt_q <= cnt_q + 3'd1;
      end
   end

   assign hund = sh_q[19:16];
   assign tens = sh_q[15:12];
   assign ones = sh_q[11:8];

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment driver showing 0..99 seconds.
// Optional zero-blink feature: define SEG_BLINK_ZERO_EN.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int CLK_HZ       = 100_000_000,
   parameter int DIGIT_PERIOD = 100_000,
   parameter int BLINK_PERIOD = CLK_HZ / 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] value,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       frame_tick
);

   localparam int PW = $clog2(DIGIT_PERIOD);

   if (DIGIT_PERIOD < 16 || BLINK_PERIOD < 2) begin : g_cfg_bad
      $error("seg_scan_driver: period parameter out of range");
   end

   logic [PW-1:0] presc_q;
   logic          tc;
   logic [1:0]    idx_q;
   logic          wrap;
   logic [7:0]    cap_q;
   logic          start_q;
   logic          ft_q;
   disp_t         disp_q;
   logic          cv_busy;
   logic          cv_done;
   bcd_t          cv_hund;
   bcd_t          cv_tens;
   bcd_t          cv_ones;
   logic [3:0]    an_d;
   logic [6:0]    seg_d;
   logic [3:0]    an_q;
   logic [6:0]    seg_q;
   logic          dp_q;

   assign tc   = (presc_q == PW'(DIGIT_PERIOD - 1));
   assign wrap = tc && (idx_q == 2'd3);

   // digit-slot prescaler
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         presc_q <= '0;
      else if (tc)
         presc_q <= '0;
      else
         presc_q <= presc_q + 1'b1;
   end

   // digit index, advances once per slot
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         idx_q <= '0;
      else if (tc)
         idx_q <= idx_q + 2'd1;
   end

   // frame start: sample value, pulse frame_tick, queue a conversion
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cap_q   <= '0;
         start_q <= 1'b0;
         ft_q    <= 1'b0;
      end else begin
         start_q <= wrap;
         ft_q    <= wrap;
         if (wrap)
            cap_q <= value;
      end
   end

   bin2bcd_seq u_bcd (
      .clk   (clk),
      .rst   (rst),
      .start (start_q && !cv_busy),
      .bin   (cap_q),
      .busy  (cv_busy),
      .done  (cv_done),
      .hund  (cv_hund),
      .tens  (cv_tens),
      .ones  (cv_ones)
   );

   // shown digits change only when a conversion completes
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         disp_q <= '0;
      else if (cv_done)
         disp_q <= '{dash: (cv_hund != 4'd0),
                     tens: cv_tens,
                     ones: cv_ones};
   end

`ifdef SEG_BLINK_ZERO_EN
   localparam int BW = $clog2(BLINK_PERIOD);

   logic [BW-1:0] blink_cnt_q;
   logic          blink_off_q;
   logic          disp_zero;

   assign disp_zero = !disp_q.dash
                   && (disp_q.tens == 4'd0)
                   && (disp_q.ones == 4'd0);

   // blink phase toggles every BLINK_PERIOD cycles
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blink_cnt_q <= '0;
         blink_off_q <= 1'b0;
      end else if (blink_cnt_q == BW'(BLINK_PERIOD - 1)) begin
         blink_cnt_q <= '0;
         blink_off_q <= !blink_off_q;
      end else begin
         blink_cnt_q <= blink_cnt_q + 1'b1;
      end
   end
`endif

   // slot decode: ones on digit 0, tens on digit 1, 3:2 stay dark
   always_comb begin
      an_d  = 4'hF;
      seg_d = SEG_BLANK;
      unique case (1'b1)
         (idx_q == 2'd0): begin
            an_d  = 4'b1110;
            seg_d = disp_q.dash ? SEG_DASH : seg_font(disp_q.ones);
         end
         (idx_q == 2'd1): begin
            an_d  = 4'b1101;
            seg_d = disp_q.dash ? SEG_DASH : seg_font(disp_q.tens);
         end
         default: ;
      endcase
`ifdef SEG_BLINK_ZERO_EN
      if (blink_off_q && disp_zero)
         an_d = 4'hF;
`endif
   end

   // registered pad drivers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an_q  <= 4'hF;
         seg_q <= SEG_BLANK;
         dp_q  <= 1'b1;
      end else begin
         an_q  <= an_d;
         seg_q <= seg_d;
         dp_q  <= 1'b1;
      end
   end

   assign an         = an_q;
   assign seg        = seg_q;
   assign dp         = dp_q;
   assign frame_tick = ft_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver (DIGIT_PERIOD=16, BLINK_PERIOD=64).
// Expectations follow SEG_BLINK_ZERO_EN when it is defined.
module tb_seg_scan_driver;

   localparam int DP  = 16;
   localparam int BP  = 64;
   localparam int FRM = 4 * DP;
   localparam int NV  = 20;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] value = 8'd0;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;
   logic       frame_tick;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_tick = -1;
   bit mon_en = 1'b0;
   bit mon_busy = 1'b0;

   typedef struct {
      int         v;
      logic [6:0] s0;
      logic [6:0] s1;
      logic [3:0] a0;
      logic [3:0] a1;
   } exp_t;

   exp_t q[$];

   logic [6:0] font [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   seg_scan_driver #(
      .CLK_HZ       (100_000_000),
      .DIGIT_PERIOD (DP),
      .BLINK_PERIOD (BP)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .value      (value),
      .an         (an),
      .seg        (seg),
      .dp         (dp),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   // blink is off during odd 64-cycle windows counted from reset release
   function automatic bit blink_dark(input int v, input int k);
`ifdef SEG_BLINK_ZERO_EN
      return (v == 0) && (k % 2 == 1);
`else
      return 1'b0;
`endif
   endfunction

   // what frame k should show when value v was captured at its start
   function automatic exp_t model(input int v, input int k);
      exp_t e;
      e.v = v;
      if (v > 99) begin
         e.s0 = 7'h3F;
         e.s1 = 7'h3F;
      end else begin
         e.s0 = font[v % 10];
         e.s1 = font[v / 10];
      end
      e.a0 = blink_dark(v, k) ? 4'hF : 4'b1110;
      e.a1 = blink_dark(v, k) ? 4'hF : 4'b1101;
      return e;
   endfunction

   task automatic wait_tick(input string nm);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_tick && n < 200);
      chk(nm, frame_tick, 1);
   endtask

   // monitor: at each frame_tick pop one expectation, check every slot
   initial begin
      exp_t e;
      bit   have;
      forever begin
         @(negedge clk);
         if (mon_en && frame_tick) begin
            mon_busy = 1'b1;
            if (last_tick >= 0)
               chk("frame_period", cyc - last_tick, FRM);
            last_tick = cyc;
            have = (q.size() != 0);
            if (have) begin
               e = q.pop_front();
            end else begin
               checks++;
               errors++;
               $display("FAIL scoreboard_empty at cycle %0d", cyc);
            end
            @(negedge clk);
            chk("tick_width", frame_tick, 0);
            repeat (14) @(negedge clk);
            if (have) begin
               chk($sformatf("slot0_an v=%0d", e.v), an, e.a0);
               chk($sformatf("slot0_seg v=%0d", e.v), seg, e.s0);
            end
            repeat (16) @(negedge clk);
            if (have) begin
               chk($sformatf("slot1_an v=%0d", e.v), an, e.a1);
               chk($sformatf("slot1_seg v=%0d", e.v), seg, e.s1);
            end
            chk("dp_off", dp, 1);
            repeat (16) @(negedge clk);
            chk("slot2_an", an, 4'hF);
            repeat (16) @(negedge clk);
            chk("slot3_an", an, 4'hF);
            mon_busy = 1'b0;
         end
      end
   end

   initial begin
      int vals [NV];
      int n;
      int dcount;
      int dark;
      int fixed_v [12] = '{59, 7, 150, 59, 58, 0, 0, 9, 10, 99, 100, 255};

      for (int i = 0; i < NV; i++)
         vals[i] = (i < 12) ? fixed_v[i] : int'($urandom_range(0, 255));

      // reset state
      value = vals[0][7:0];
      q.push_back(model(vals[0], 1));
      repeat (3) @(negedge clk);
      chk("rst_an", an, 4'hF);
      chk("rst_seg", seg, 7'h7F);
      chk("rst_dp", dp, 1);
      chk("rst_tick", frame_tick, 0);
      rst = 1'b0;
      mon_en = 1'b1;

      // random mid-frame value changes, each seen in the following frame
      for (int i = 1; i < NV; i++) begin
         wait_tick($sformatf("tick_%0d", i));
         repeat ($urandom_range(1, 40)) @(negedge clk);
         value = vals[i][7:0];
         q.push_back(model(vals[i], i + 1));
      end
      wait_tick("tick_last");
      n = 0;
      while ((q.size() != 0 || mon_busy) && n < 300) begin
         @(negedge clk);
         n++;
      end
      mon_en = 1'b0;
      chk("scoreboard_drained", q.size(), 0);

      // reset during a conversion
      wait_tick("tick_conv");
      repeat (3) @(negedge clk);
      chk("conv_in_flight", dut.u_bcd.busy, 1);
      rst = 1'b1;
      #1;
      chk("midrst_an", an, 4'hF);
      chk("midrst_seg", seg, 7'h7F);
      chk("midrst_dp", dp, 1);
      chk("midrst_tick", frame_tick, 0);
      dcount = 0;
      repeat (10) begin
         @(negedge clk);
         if (dut.u_bcd.done) dcount++;
      end
      chk("done_after_abort", dcount, 0);
      value = 8'd0;
      rst = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 15) begin
            chk("cleared_an", an, 4'b1110);
            chk("cleared_seg", seg, 7'h40);
         end
      end while (!frame_tick && n < 200);
      chk("first_tick_delay", n, FRM);

      // value 0 held: blink windows or steady 00
      for (int k = 1; k <= 4; k++) begin
         dark = 0;
         for (int o = 1; o < FRM; o++) begin
            @(negedge clk);
            if (an == 4'hF) dark++;
            if (o == 15)
               chk($sformatf("zero_seg_f%0d", k), seg, 7'h40);
         end
         chk($sformatf("zero_dark_f%0d", k), dark,
             blink_dark(0, k) ? FRM - 1 : 2 * DP - 1);
         if (k < 4)
            wait_tick($sformatf("zero_tick_%0d", k));
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
